// File: rtl/servant_uart_rx_fifo.sv
// rtl/servant_uart_rx_fifo.sv - 4-entry byte FIFO for received UART characters
// A push while full is taken only when a pop frees the slot in the same cycle.

module servant_uart_rx_fifo (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam logic [2:0] DEPTH = 3'd4;

  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       do_push;
  logic       do_pop;

  assign empty_o = (count_q == 3'd0);
  assign full_o  = (count_q == DEPTH);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/servant_uart_rx.sv
// rtl/servant_uart_rx.sv - 8N1 UART receiver with 4-byte FIFO and a small register port
// Samples mid-bit using one down-counter; DATA pops on read, STATUS holds sticky error flags.

module servant_uart_rx #(
  parameter int frequency = 32,
  parameter int baud_rate = 115200
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_rx,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq
);

  localparam int DIV = (frequency * 1000000) / baud_rate;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;
  localparam int   BIT_NEMPTY = 0;
  localparam int   BIT_OVR    = 1;
  localparam int   BIT_FERR   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          fall;
  logic          tick;
  logic          push;
  logic          ferr_set;

  logic          ack_q;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
  logic          bus_rd, bus_wr;
  logic          pop;
  logic          ovr_set;
  logic [7:0]    fifo_rdata;
  logic          fifo_empty;
  logic          fifo_full;
  logic [31:0]   status_word;
  logic          unused_wb_dat;

  assign unused_wb_dat = ^{i_wb_dat[31:3], i_wb_dat[0]};

  // Flop 3 remembers the previous synchronized level so the falling edge is seen exactly once.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall = rx_prev_q & ~rx_sync_q;
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = rx_sync_q ? ST_IDLE : ST_DATA;
          cnt_d   = FULL_LOAD;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          cnt_d   = FULL_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          push     = rx_sync_q;
          ferr_set = ~rx_sync_q;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  servant_uart_rx_fifo u_fifo (
    .clk_i   (wb_clk),
    .rst_i   (wb_rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (shreg_q),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Every bus access, read or write, completes in the cycle ack is high.
  assign bus_rd  = ack_q & ~i_wb_we;
  assign bus_wr  = ack_q & i_wb_we;
  assign pop     = bus_rd & (i_wb_adr == ADR_DATA) & ~fifo_empty;
  assign ovr_set = push & fifo_full & ~pop;

  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (bus_wr && (i_wb_adr == ADR_STATUS)) begin
      if (i_wb_dat[BIT_OVR]) begin
        ovr_d = 1'b0;
      end
      if (i_wb_dat[BIT_FERR]) begin
        ferr_d = 1'b0;
      end
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end
    if (ferr_set) begin
      ferr_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_q  <= 1'b0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ack_q  <= i_wb_cyc & ~ack_q;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  always_comb begin
    status_word             = 32'd0;
    status_word[BIT_NEMPTY] = ~fifo_empty;
    status_word[BIT_OVR]    = ovr_q;
    status_word[BIT_FERR]   = ferr_q;
  end

  always_comb begin
    o_wb_rdt = 32'd0;
    if (bus_rd) begin
      if (i_wb_adr == ADR_STATUS) begin
        o_wb_rdt = status_word;
      end else if (!fifo_empty) begin
        o_wb_rdt = {24'd0, fifo_rdata};
      end
    end
  end

  assign o_wb_ack = ack_q;
  assign o_irq    = ~fifo_empty;

endmodule

// File: doc/servant_uart_rx.md
SERVANT_UART_RX -- requirements
Module: servant_uart_rx

Interface
REQ-001 SHALL have parameter frequency, default 32: wb_clk frequency in MHz.
REQ-002 SHALL have parameter baud_rate, default 115200: serial bit rate in bit/s.
REQ-003 SHALL have port wb_clk  input  1  system clock; the only clock.
REQ-004 SHALL have port wb_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_rx  input  1  asynchronous serial line, idle high, 8N1.
REQ-006 SHALL have port i_wb_adr  input  1  register select: 0 = DATA, 1 = STATUS.
REQ-007 SHALL have port i_wb_dat  input  32  write data.
REQ-008 SHALL have port i_wb_we  input  1  write enable.
REQ-009 SHALL have port i_wb_cyc  input  1  cycle/strobe.
REQ-010 SHALL have port o_wb_rdt  output  32  read data.
REQ-011 SHALL have port o_wb_ack  output  1  single-cycle acknowledge.
REQ-012 SHALL have port o_irq  output  1  high while the FIFO is non-empty.

Function
REQ-013 SHALL pass i_rx through a 2-flop synchronizer before use.
REQ-014 SHALL compute DIV = frequency*1000000/baud_rate, truncated; SHALL use one counter wide enough for DIV-1.
REQ-015 SHALL implement states IDLE, START, DATA, STOP.
REQ-016 IDLE: on a synchronized falling edge -> START; load the counter with DIV/2-1.
REQ-017 START: at terminal count, a sampled 1 is a false start -> IDLE; a sampled 0 -> DATA; reload DIV-1.
REQ-018 DATA: sample once per DIV cycles; shift LSB first; after 8 samples -> STOP.
REQ-019 STOP: sampled 1 -> push byte into the FIFO; sampled 0 -> discard byte and set sticky ferr; both -> IDLE.
REQ-020 SHALL take the IDLE transition from STOP in the same cycle the stop bit is sampled; a start edge 1 cycle later SHALL be accepted.
REQ-021 FIFO: 4 entries, 8 bits each, with wrapping 2-bit pointers and a 3-bit count.
REQ-022 A push when full SHALL drop the new byte, leave FIFO contents unchanged and set sticky ovr.
REQ-023 A simultaneous push and pop SHALL succeed even when full; count unchanged.
REQ-024 o_wb_ack SHALL be registered: ack = i_wb_cyc & ~ack, so it is high in the cycle after cyc rises and low the cycle after that.
REQ-025 A DATA read SHALL return {24'b0, head byte} and pop in the ack cycle; when the FIFO is empty it SHALL return 0 and not pop.
REQ-026 A STATUS read SHALL return {29'b0, ferr, ovr, ~empty} in bits [2:0].
REQ-027 A STATUS write with i_wb_dat[1]=1 SHALL clear ovr; with i_wb_dat[2]=1 it SHALL clear ferr; a same-cycle set wins.
REQ-028 A DATA write SHALL be acknowledged and otherwise ignored.
REQ-029 o_wb_rdt SHALL be valid in the ack cycle and 0 otherwise.

Reset
REQ-030 wb_rst SHALL be sampled on the wb_clk rising edge only.
REQ-031 Reset SHALL give: state IDLE, synchronizer flops 1, FIFO empty, ovr=0, ferr=0, o_wb_ack=0, o_wb_rdt=0, o_irq=0.
REQ-032 Reset mid-frame SHALL abort the frame without pushing; the next falling edge after release starts a new frame.

Structure
REQ-033 SHALL need no shared package; state encoding, register offsets and status bit positions SHALL be localparams.
REQ-034 SHALL contain the FIFO as one sub-module, servant_uart_rx_fifo (push, pop, data in/out, empty, full).

Verification (frequency=32, baud_rate=1000000, DIV=32)
REQ-035 Send 0x55 -> o_irq rises; DATA read returns 0x00000055; next STATUS read returns 0x0.
REQ-036 Send 0x01,0x02,0x03,0x04,0x05 without reads -> STATUS=0x3; DATA reads return 1,2,3,4 then 0.
REQ-037 Send 0xA5 with stop bit driven 0 -> FIFO empty; STATUS=0x4; STATUS write 0x4 -> STATUS=0x0.
REQ-038 Low glitch of 10 cycles on i_rx -> no push; state back to IDLE; STATUS=0x0.
REQ-039 Assert wb_rst during DATA of 0x3C, then send 0xC3 -> only 0xC3 is read.
REQ-040 Back-to-back 0xFF,0x00 with zero idle gap, and a DATA read coinciding with the second push -> both bytes received in order; no ovr.
